// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC bitstream front end.
package cavlc_pkg;

    localparam int WIN_W     = 16;
    localparam int MAX_SHIFT = 16;

    typedef enum logic [1:0] {
        CMD_U    = 2'd0,
        CMD_UE   = 2'd1,
        CMD_SE   = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CMD,
        ST_EXEC,
        ST_SUFFIX,
        ST_RSP
    } state_e;

    // Signed Exp-Golomb mapping: odd k -> (k+1)/2, even k -> -(k/2).
    // (k>>1)+1 equals (k+1)>>1 for odd k and cannot overflow 16 bits.
    function automatic logic [15:0] se_map(input logic [15:0] code_num);
        if (code_num[0]) begin
            se_map = (code_num >> 1) + 16'd1;
        end else begin
            se_map = 16'd0 - (code_num >> 1);
        end
    endfunction

endpackage

// File: rtl/lzc16.sv
// Combinational leading-zero counter over a 16-bit window.
// count = 16 and all_zero = 1 when no bit is set.
module lzc16
    import cavlc_pkg::*;
(
    input  logic [WIN_W-1:0] win,
    output logic [4:0]       count,
    output logic             all_zero
);

    // Scan LSB to MSB so the highest set bit is the last one to write count.
    always_comb begin
        count = 5'd16;
        for (int i = 0; i < WIN_W; i++) begin
            if (win[i]) begin
                count = 5'(WIN_W - 1 - i);
            end
        end
    end

    assign all_zero = (win == '0);

endmodule

// File: rtl/bitstream_read_ctrl.sv
// Command sequencer above the barrel shifter: executes u(n), ue(v) and
// se(v) reads against the 16-bit lookahead window and returns the decoded
// value on a valid/ready response channel. Sole owner of shift requests.
module bitstream_read_ctrl
    import cavlc_pkg::*;
(
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic        ShifterReady,
    input  logic [15:0] BitstreamShifted,
    output logic        ShiftEn,
    output logic [4:0]  NumShift,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [1:0]  CmdType,
    input  logic [4:0]  CmdLen,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [15:0] RspData,
    output logic        Error
);

    state_e      state_q,     state_d;
    cmd_type_e   cmd_type_q,  cmd_type_d;
    logic [4:0]  cmd_len_q,   cmd_len_d;
    logic [3:0]  lz_q,        lz_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        error_q,     error_d;

    logic        shift_en;
    logic [4:0]  num_shift;
    logic        cmd_ready;
    logic [4:0]  lz;
    logic        win_zero;
    logic [15:0] info;
    logic [15:0] code_num;

    lzc16 u_lzc (
        .win      (BitstreamShifted),
        .count    (lz),
        .all_zero (win_zero)
    );

    // Exp-Golomb suffix value: prefix length lz_q was consumed in EXEC, so
    // the window now starts with the lz_q info bits.
    assign info     = BitstreamShifted >> (5'd16 - {1'b0, lz_q});
    assign code_num = (16'd1 << lz_q) - 16'd1 + info;

    // Next-state, shift request and response capture.
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_type_d  = cmd_type_q;
        cmd_len_d   = cmd_len_q;
        lz_d        = lz_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        error_d     = error_q;
        shift_en    = 1'b0;
        num_shift   = 5'd0;
        cmd_ready   = 1'b0;

        if (!Enable) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_data_d  = '0;
            error_d     = 1'b0;
        end else if (state_q != ST_IDLE && !ShifterReady) begin
            // Window no longer trustworthy: drop whatever is in flight.
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ShifterReady) state_d = ST_WAIT_CMD;
                end
                ST_WAIT_CMD: begin
                    cmd_ready = 1'b1;
                    if (CmdValid) begin
                        cmd_type_d = cmd_type_e'(CmdType);
                        cmd_len_d  = CmdLen;
                        state_d    = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    unique case (cmd_type_q)
                        CMD_U: begin
                            if (cmd_len_q > 5'(MAX_SHIFT)) begin
                                error_d = 1'b1;
                            end else if (cmd_len_q != 5'd0) begin
                                shift_en   = 1'b1;
                                num_shift  = cmd_len_q;
                                rsp_data_d = BitstreamShifted >> (5'd16 - cmd_len_q);
                            end
                        end
                        CMD_UE, CMD_SE: begin
                            if (win_zero) begin
                                error_d = 1'b1;
                            end else begin
                                shift_en  = 1'b1;
                                num_shift = lz + 5'd1;
                                lz_d      = lz[3:0];
                                if (lz != 5'd0) begin
                                    state_d     = ST_SUFFIX;
                                    rsp_valid_d = 1'b0;
                                end
                            end
                        end
                        default: begin
                            error_d = 1'b1;
                        end
                    endcase
                end
                ST_SUFFIX: begin
                    shift_en    = 1'b1;
                    num_shift   = {1'b0, lz_q};
                    rsp_data_d  = (cmd_type_q == CMD_SE) ? se_map(code_num) : code_num;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
                ST_RSP: begin
                    if (RspReady) begin
                        rsp_valid_d = 1'b0;
                        state_d     = ST_WAIT_CMD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            cmd_type_q  <= CMD_U;
            cmd_len_q   <= '0;
            lz_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_type_q  <= cmd_type_d;
            cmd_len_q   <= cmd_len_d;
            lz_q        <= lz_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            error_q     <= error_d;
        end
    end

    assign ShiftEn  = shift_en;
    assign NumShift = shift_en ? num_shift : 5'd0;
    assign CmdReady = cmd_ready;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_bitstream_read_ctrl.sv
// Bench for bitstream_read_ctrl: a bit-array shifter model feeds the window,
// and a reference decoder walks the same bit array independently.
module tb_bitstream_read_ctrl;

    localparam int NBITS = 32768;

    logic        Clk;
    logic        nReset;
    logic        Enable;
    logic        ShifterReady;
    logic [15:0] BitstreamShifted;
    logic        ShiftEn;
    logic [4:0]  NumShift;
    logic        CmdValid;
    logic        CmdReady;
    logic [1:0]  CmdType;
    logic [4:0]  CmdLen;
    logic        RspValid;
    logic        RspReady;
    logic [15:0] RspData;
    logic        Error;

    logic stream [NBITS];
    int   pos;
    int   shift_count;
    int   amt;
    int   ref_pos;
    bit   ref_err;
    bit   mon_on;
    int   exec_shift;
    int   suffix_shift;
    int   errors;
    int   checks;

    bitstream_read_ctrl dut (
        .Clk              (Clk),
        .nReset           (nReset),
        .Enable           (Enable),
        .ShifterReady     (ShifterReady),
        .BitstreamShifted (BitstreamShifted),
        .ShiftEn          (ShiftEn),
        .NumShift         (NumShift),
        .CmdValid         (CmdValid),
        .CmdReady         (CmdReady),
        .CmdType          (CmdType),
        .CmdLen           (CmdLen),
        .RspValid         (RspValid),
        .RspReady         (RspReady),
        .RspData          (RspData),
        .Error            (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int bit_at(int p);
        return (p < NBITS) ? int'(stream[p]) : 0;
    endfunction

    function automatic logic [15:0] win_at(int p);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = bit_at(p + i)[0];
        return w;
    endfunction

    // Barrel shifter model: a shift requested in cycle t shows in cycle t+1.
    always @(posedge Clk) begin
        amt = ShiftEn ? int'(NumShift) : 0;
        #1;
        pos = pos + amt;
        if (amt != 0) shift_count = shift_count + 1;
        BitstreamShifted = win_at(pos);
    end

    // Shift request sanity on every cycle.
    always @(negedge Clk) begin
        if (mon_on) begin
            checks = checks + 1;
            if ((ShiftEn !== 1'b1 && NumShift !== 5'd0) || NumShift > 5'd16) begin
                errors = errors + 1;
                $display("FAIL shift_sanity: ShiftEn=%b NumShift=%0d", ShiftEn, NumShift);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    // ---------------- reference decoder ----------------
    task automatic model_cmd(input int typ, input int len,
                             output logic [15:0] exp_data, output int exp_lat);
        int lz, info, k, s, v;
        exp_data = 16'h0;
        exp_lat  = 2;
        if (typ == 3 || (typ == 0 && len > 16)) begin
            ref_err = 1'b1;
        end else if (typ == 0) begin
            v = 0;
            for (int i = 0; i < len; i++) v = v * 2 + bit_at(ref_pos + i);
            ref_pos  = ref_pos + len;
            exp_data = 16'(v);
        end else begin
            lz = 0;
            while (lz < 16 && bit_at(ref_pos + lz) == 0) lz++;
            if (lz == 16) begin
                ref_err = 1'b1;
            end else begin
                info = 0;
                for (int i = 0; i < lz; i++) info = info * 2 + bit_at(ref_pos + lz + 1 + i);
                k = (1 << lz) - 1 + info;
                ref_pos = ref_pos + 2 * lz + 1;
                if (lz > 0) exp_lat = 3;
                if (typ == 1) exp_data = 16'(k);
                else begin
                    s = (k % 2 == 1) ? (k + 1) / 2 : -(k / 2);
                    exp_data = 16'(s);
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic settle();
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic fill_pattern(input logic [31:0] pat);
        for (int i = 0; i < 32; i++) stream[pos + i] = pat[31-i];
        for (int i = 32; i < 64; i++) stream[pos + i] = 1'b0;
        ref_pos = pos;
        settle();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2048; i++) stream[pos + i] = ($urandom_range(0, 2) == 0);
        ref_pos = pos;
        settle();
    endtask

    task automatic wait_cmd_ready(input string tag);
        int k = 0;
        while (CmdReady !== 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        checks = checks + 1;
        if (CmdReady !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL %s_cmd_ready: got %b expected 1", tag, CmdReady);
        end
    endtask

    task automatic do_cmd(input int typ, input int len, input int hold,
                          input string tag, output logic [15:0] got);
        logic [15:0] exp_data;
        int exp_lat, k;
        model_cmd(typ, len, exp_data, exp_lat);
        got = 16'hxxxx;
        @(negedge Clk);
        CmdValid = 1'b1;
        CmdType  = 2'(typ);
        CmdLen   = 5'(len);
        wait_cmd_ready(tag);
        @(negedge Clk);
        CmdValid   = 1'b0;
        k          = 1;
        exec_shift = ShiftEn ? int'(NumShift) : 0;
        suffix_shift = 0;
        while (RspValid !== 1'b1 && k < 8) begin
            @(negedge Clk);
            k++;
            if (k == 2 && RspValid !== 1'b1) suffix_shift = ShiftEn ? int'(NumShift) : 0;
        end
        checks = checks + 1;
        if (RspValid !== 1'b1 || k != exp_lat) begin
            errors = errors + 1;
            $display("FAIL %s_latency: got %0d (valid=%b) expected %0d", tag, k, RspValid, exp_lat);
        end
        for (int h = 0; h < hold; h++) begin
            checks = checks + 1;
            if (RspValid !== 1'b1 || RspData !== exp_data) begin
                errors = errors + 1;
                $display("FAIL %s_hold: valid=%b data=%h expected %h", tag, RspValid, RspData, exp_data);
            end
            @(negedge Clk);
        end
        got = RspData;
        checks = checks + 3;
        if (RspData !== exp_data) begin
            errors = errors + 1;
            $display("FAIL %s_data: got %h expected %h", tag, RspData, exp_data);
        end
        if (Error !== ref_err) begin
            errors = errors + 1;
            $display("FAIL %s_error: got %b expected %b", tag, Error, ref_err);
        end
        if (pos != ref_pos) begin
            errors = errors + 1;
            $display("FAIL %s_bitpos: got %0d expected %0d", tag, pos, ref_pos);
        end
        RspReady = 1'b1;
        @(negedge Clk);
        RspReady = 1'b0;
        checks = checks + 1;
        if (RspValid !== 1'b0 || CmdReady !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL %s_release: RspValid=%b CmdReady=%b expected 0/1", tag, RspValid, CmdReady);
        end
    endtask

    task automatic enable_pulse(input string tag);
        @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);
        checks = checks + 1;
        if (Error !== 1'b0 || CmdReady !== 1'b0 || RspValid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s_disabled: Error=%b CmdReady=%b RspValid=%b expected 0/0/0",
                     tag, Error, CmdReady, RspValid);
        end
        Enable  = 1'b1;
        ref_err = 1'b0;
        wait_cmd_ready(tag);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nReset = 1'b0;
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        mon_on = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            checks = checks + 1;
            if ({ShiftEn, NumShift, CmdReady, RspValid, RspData, Error} !== '0) begin
                errors = errors + 1;
                $display("FAIL reset_outputs: cycle %0d ShiftEn=%b NumShift=%0d CmdReady=%b RspValid=%b RspData=%h Error=%b expected all 0",
                         c, ShiftEn, NumShift, CmdReady, RspValid, RspData, Error);
            end
        end
        ShifterReady = 1'b1;
        #1;
        checks = checks + 1;
        if (CmdReady !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL startup_idle: CmdReady=%b expected 0", CmdReady);
        end
        @(negedge Clk);
        checks = checks + 1;
        if (CmdReady !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL startup_ready: CmdReady=%b expected 1", CmdReady);
        end
    endtask

    task automatic test_fixed_len();
        logic [15:0] got;
        fill_pattern(32'hA5F0_1234);
        do_cmd(0, 4, 0, "u4", got);
        checks = checks + 2;
        if (got !== 16'h000A) begin
            errors = errors + 1;
            $display("FAIL u4_value: got %h expected 000a", got);
        end
        if (exec_shift != 4) begin
            errors = errors + 1;
            $display("FAIL u4_shift: got %0d expected 4", exec_shift);
        end
        do_cmd(0, 16, 0, "u16", got);
        checks = checks + 1;
        if (got !== 16'h5F01) begin
            errors = errors + 1;
            $display("FAIL u16_value: got %h expected 5f01", got);
        end
        do_cmd(0, 0, 0, "u0", got);
        checks = checks + 1;
        if (exec_shift != 0) begin
            errors = errors + 1;
            $display("FAIL u0_shift: got %0d expected 0", exec_shift);
        end
    endtask

    task automatic test_exp_golomb();
        logic [15:0] got;
        fill_pattern(32'h2800_0000);
        do_cmd(1, 0, 0, "ue", got);
        checks = checks + 2;
        if (got !== 16'd4) begin
            errors = errors + 1;
            $display("FAIL ue_value: got %h expected 0004", got);
        end
        if (exec_shift != 3 || suffix_shift != 2) begin
            errors = errors + 1;
            $display("FAIL ue_shifts: got %0d,%0d expected 3,2", exec_shift, suffix_shift);
        end
        fill_pattern(32'h2800_0000);
        do_cmd(2, 0, 0, "se_neg", got);
        checks = checks + 1;
        if (got !== 16'hFFFE) begin
            errors = errors + 1;
            $display("FAIL se_neg_value: got %h expected fffe", got);
        end
        fill_pattern(32'h8000_0000);
        do_cmd(2, 0, 0, "se_zero", got);
        checks = checks + 1;
        if (got !== 16'h0000 || exec_shift != 1) begin
            errors = errors + 1;
            $display("FAIL se_zero: got %h shift %0d expected 0000 shift 1", got, exec_shift);
        end
    endtask

    task automatic test_errors();
        logic [15:0] got;
        fill_pattern(32'h0000_0000);
        do_cmd(1, 0, 0, "ue_allzero", got);
        checks = checks + 1;
        if (exec_shift != 0) begin
            errors = errors + 1;
            $display("FAIL ue_allzero_shift: got %0d expected 0", exec_shift);
        end
        do_cmd(0, 20, 0, "u20", got);
        repeat (5) @(negedge Clk);
        checks = checks + 1;
        if (Error !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL error_sticky: got %b expected 1", Error);
        end
        enable_pulse("err_clear");
        fill_pattern(32'h4000_0000);
        do_cmd(3, 0, 0, "reserved", got);
        enable_pulse("rsvd_clear");
    endtask

    task automatic test_hold_and_abort();
        logic [15:0] got;
        logic [15:0] exp_data;
        int exp_lat, p0, sc;
        fill_pattern(32'hC3A5_0000);
        do_cmd(0, 8, 10, "hold", got);

        // Enable dropped while the suffix of a 3-zero prefix is being read.
        fill_pattern(32'h1600_0000);
        p0 = ref_pos;
        @(negedge Clk);
        CmdValid = 1'b1;
        CmdType  = 2'd1;
        wait_cmd_ready("abort");
        @(negedge Clk);
        CmdValid = 1'b0;
        @(negedge Clk);
        checks = checks + 1;
        if (ShiftEn !== 1'b1 || NumShift !== 5'd3) begin
            errors = errors + 1;
            $display("FAIL abort_suffix: ShiftEn=%b NumShift=%0d expected 1/3", ShiftEn, NumShift);
        end
        Enable = 1'b0;
        #1;
        checks = checks + 1;
        if (ShiftEn !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_shift_gate: got %b expected 0", ShiftEn);
        end
        sc = shift_count;
        @(negedge Clk);
        checks = checks + 1;
        if (RspValid !== 1'b0 || CmdReady !== 1'b0 || Error !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_outputs: RspValid=%b CmdReady=%b Error=%b expected 0/0/0",
                     RspValid, CmdReady, Error);
        end
        repeat (3) @(negedge Clk);
        checks = checks + 2;
        if (shift_count != sc) begin
            errors = errors + 1;
            $display("FAIL abort_no_shift: got %0d shifts expected %0d", shift_count, sc);
        end
        if (pos != p0 + 4) begin
            errors = errors + 1;
            $display("FAIL abort_bitpos: got %0d expected %0d", pos, p0 + 4);
        end
        Enable  = 1'b1;
        ref_pos = p0 + 4;
        ref_err = 1'b0;
        wait_cmd_ready("abort_resume");

        // ShifterReady lost while a response is pending.
        fill_pattern(32'h9000_0000);
        model_cmd(0, 4, exp_data, exp_lat);
        @(negedge Clk);
        CmdValid = 1'b1;
        CmdType  = 2'd0;
        CmdLen   = 5'd4;
        wait_cmd_ready("srdy");
        @(negedge Clk);
        CmdValid = 1'b0;
        @(negedge Clk);
        checks = checks + 1;
        if (RspValid !== 1'b1 || RspData !== exp_data) begin
            errors = errors + 1;
            $display("FAIL srdy_rsp: valid=%b data=%h expected 1/%h", RspValid, RspData, exp_data);
        end
        ShifterReady = 1'b0;
        @(negedge Clk);
        checks = checks + 1;
        if (RspValid !== 1'b0 || CmdReady !== 1'b0 || Error !== ref_err) begin
            errors = errors + 1;
            $display("FAIL srdy_drop: RspValid=%b CmdReady=%b Error=%b expected 0/0/%b",
                     RspValid, CmdReady, Error, ref_err);
        end
        ShifterReady = 1'b1;
        wait_cmd_ready("srdy_resume");
        checks = checks + 1;
        if (pos != ref_pos) begin
            errors = errors + 1;
            $display("FAIL srdy_bitpos: got %0d expected %0d", pos, ref_pos);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        fill_random();
        for (int i = 0; i < 12; i++) begin
            do_cmd(i % 3, (i * 5) % 17, 0, "b2b", got);
        end
    endtask

    task automatic test_random();
        logic [15:0] got;
        int typ, len;
        for (int n = 0; n < 300; n++) begin
            if (n % 40 == 0) begin
                enable_pulse("rand_clear");
                fill_random();
            end
            typ = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
            len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 31))
                                                : int'($urandom_range(0, 16));
            do_cmd(typ, len, int'($urandom_range(0, 3)), "rand", got);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        pos          = 0;
        ref_pos      = 0;
        ref_err      = 1'b0;
        shift_count  = 0;
        mon_on       = 1'b0;
        Enable       = 1'b1;
        ShifterReady = 1'b0;
        CmdValid     = 1'b0;
        CmdType      = 2'd0;
        CmdLen       = 5'd0;
        RspReady     = 1'b0;
        for (int i = 0; i < NBITS; i++) stream[i] = 1'b0;

        test_reset();
        test_fixed_len();
        test_exp_golomb();
        test_errors();
        test_hold_and_abort();
        test_back_to_back();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
